// File: rtl/seq_divider_if.sv
// seq_divider_if: operand/result bundle between the control unit and the divider
interface seq_divider_if #(parameter int WIDTH = 32);
   logic start, signed_op, busy, done, div_by_zero;
   logic [WIDTH-1:0] dividend, divisor, Z_HI, Z_LO;
   modport master(output start, signed_op, dividend, divisor, input Z_HI, Z_LO, busy, done, div_by_zero);
   modport slave(input start, signed_op, dividend, divisor, output Z_HI, Z_LO, busy, done, div_by_zero);
endinterface

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider producing Z_LO (quotient) and Z_HI (remainder)
module seq_divider #(
   parameter int WIDTH = 32,
   parameter int ITERS = WIDTH
) (
   input logic clock,
   input logic clear,
   seq_divider_if.slave bus
);
   localparam int CW = $clog2(ITERS + 1);
   typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
   state_t state_q, state_d;
   logic [WIDTH:0] shifted, diff;
   logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [WIDTH-1:0] z_hi_q, z_hi_d, z_lo_q, z_lo_d, dvd_mag, dvs_mag;
   logic [CW-1:0] cnt_q, cnt_d;
   logic qneg_q, qneg_d, rneg_q, rneg_d, busy_q, busy_d, done_q, done_d;
   logic dbz_q, dbz_d, zero_q, zero_d, accept;
   always_comb begin
      accept = state_q == IDLE && bus.start && !done_q && !zero_q;
      dvd_mag = bus.signed_op && bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
      dvs_mag = bus.signed_op && bus.divisor[WIDTH-1] ? -bus.divisor : bus.divisor;
      shifted = {rem_q, quo_q[WIDTH-1]};
      diff = shifted - {1'b0, dvs_q};
      state_d = state_q;
      rem_d = rem_q;
      quo_d = quo_q;
      dvs_d = dvs_q;
      cnt_d = cnt_q;
      qneg_d = qneg_q;
      rneg_d = rneg_q;
      busy_d = busy_q;
      done_d = 1'b0;
      dbz_d = dbz_q;
      zero_d = zero_q;
      z_hi_d = z_hi_q;
      z_lo_d = z_lo_q;
      // zero divisor skips iteration; quo_q parks the raw dividend for Z_HI
      if (accept && bus.divisor == '0) begin
         zero_d = 1'b1;
         busy_d = 1'b1;
         dbz_d = 1'b0;
         quo_d = bus.dividend;
      end else if (accept) begin
         state_d = ITER;
         busy_d = 1'b1;
         dbz_d = 1'b0;
         quo_d = dvd_mag;
         dvs_d = dvs_mag;
         rem_d = '0;
         cnt_d = '0;
         qneg_d = bus.signed_op && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
         rneg_d = bus.signed_op && bus.dividend[WIDTH-1];
      end else if (zero_q) begin
         zero_d = 1'b0;
         busy_d = 1'b0;
         done_d = 1'b1;
         dbz_d = 1'b1;
         z_lo_d = '1;
         z_hi_d = quo_q;
      end else if (state_q == ITER) begin
         rem_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
         quo_d = {quo_q[WIDTH-2:0], !diff[WIDTH]};
         cnt_d = cnt_q + 1'b1;
         state_d = cnt_q == CW'(ITERS - 1) ? FIX : ITER;
      end else if (state_q == FIX) begin
         state_d = IDLE;
         busy_d = 1'b0;
         done_d = 1'b1;
         z_lo_d = qneg_q ? -quo_q : quo_q;
         z_hi_d = rneg_q ? -rem_q : rem_q;
      end
   end
   always_ff @(posedge clock) begin
      if (clear) begin
         state_q <= IDLE;
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
         qneg_q <= 1'b0;
         rneg_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         dbz_q <= 1'b0;
         zero_q <= 1'b0;
         z_hi_q <= '0;
         z_lo_q <= '0;
      end else begin
         state_q <= state_d;
         rem_q <= rem_d;
         quo_q <= quo_d;
         dvs_q <= dvs_d;
         cnt_q <= cnt_d;
         qneg_q <= qneg_d;
         rneg_q <= rneg_d;
         busy_q <= busy_d;
         done_q <= done_d;
         dbz_q <= dbz_d;
         zero_q <= zero_d;
         z_hi_q <= z_hi_d;
         z_lo_q <= z_lo_d;
      end
   end
   assign bus.Z_HI = z_hi_q;
   assign bus.Z_LO = z_lo_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed checks of seq_divider results, timing and control corner cases
module tb_seq_divider;
   logic clk = 1'b0, rst = 1'b1;
   int tests = 0, fails = 0, cyc, dones;
   seq_divider_if bus();
   seq_divider dut(.clock(clk), .clear(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.start = 1'b1;
      bus.signed_op = s;
      bus.dividend = a;
      bus.divisor = b;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      bus.dividend = 32'hDEAD_BEEF;
      bus.divisor = 32'h0BAD_F00D;
   endtask
   task automatic wait_done(output int c);
      c = 0;
      while (bus.busy === 1'b1 && c < 200) begin
         c++;
         @(negedge clk);
      end
   endtask
   task automatic full_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lo, input logic [31:0] hi);
      start_op(s, a, b);
      chk({tag, "_busy_k"}, {31'b0, bus.busy}, 32'd1);
      wait_done(cyc);
      chk({tag, "_cycles"}, cyc, 32'd33);
      chk({tag, "_done"}, {31'b0, bus.done}, 32'd1);
      chk({tag, "_lo"}, bus.Z_LO, lo);
      chk({tag, "_hi"}, bus.Z_HI, hi);
   endtask
   initial begin
      bus.start = 1'b0;
      bus.signed_op = 1'b0;
      bus.dividend = '0;
      bus.divisor = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_hi", bus.Z_HI, 32'd0);
      chk("rst_lo", bus.Z_LO, 32'd0);
      chk("rst_busy", {31'b0, bus.busy}, 32'd0);
      chk("rst_done", {31'b0, bus.done}, 32'd0);
      chk("rst_dbz", {31'b0, bus.div_by_zero}, 32'd0);
      full_op("s100d7", 1'b1, 32'd100, 32'd7, 32'h0000000E, 32'h00000002);
      // start while done is high must be dropped
      bus.start = 1'b1;
      bus.signed_op = 1'b0;
      bus.dividend = 32'd9;
      bus.divisor = 32'd3;
      @(negedge clk);
      bus.start = 1'b0;
      chk("start_on_done_busy", {31'b0, bus.busy}, 32'd0);
      chk("done_one_cycle", {31'b0, bus.done}, 32'd0);
      chk("start_on_done_lo", bus.Z_LO, 32'h0000000E);
      full_op("sm100d7", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE);
      full_op("s100dm7", 1'b1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'h00000002);
      full_op("u_ffff_d2", 1'b0, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 32'h00000001);
      full_op("s_m1_d2", 1'b1, 32'hFFFFFFFF, 32'd2, 32'h00000000, 32'hFFFFFFFF);
      start_op(1'b0, 32'h00001234, 32'd0);
      chk("dz_busy_k", {31'b0, bus.busy}, 32'd1);
      wait_done(cyc);
      chk("dz_cycles", cyc, 32'd1);
      chk("dz_done", {31'b0, bus.done}, 32'd1);
      chk("dz_flag", {31'b0, bus.div_by_zero}, 32'd1);
      chk("dz_lo", bus.Z_LO, 32'hFFFFFFFF);
      chk("dz_hi", bus.Z_HI, 32'h00001234);
      start_op(1'b0, 32'd9, 32'd3);
      chk("dz_clear_at_accept", {31'b0, bus.div_by_zero}, 32'd0);
      wait_done(cyc);
      chk("u9d3_cycles", cyc, 32'd33);
      chk("u9d3_lo", bus.Z_LO, 32'd3);
      chk("u9d3_hi", bus.Z_HI, 32'd0);
      start_op(1'b1, 32'h80000000, 32'hFFFFFFFF);
      repeat (9) @(negedge clk);
      bus.start = 1'b1;
      bus.signed_op = 1'b0;
      bus.dividend = 32'd1000;
      bus.divisor = 32'd3;
      @(negedge clk);
      bus.start = 1'b0;
      chk("ovf_mid_lo_held", bus.Z_LO, 32'd3);
      wait_done(cyc);
      chk("ovf_cycles_left", cyc, 32'd23);
      chk("ovf_done", {31'b0, bus.done}, 32'd1);
      chk("ovf_lo", bus.Z_LO, 32'h80000000);
      chk("ovf_hi", bus.Z_HI, 32'd0);
      chk("ovf_dbz", {31'b0, bus.div_by_zero}, 32'd0);
      start_op(1'b1, 32'd100, 32'd7);
      repeat (11) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("clr_busy", {31'b0, bus.busy}, 32'd0);
      chk("clr_hi", bus.Z_HI, 32'd0);
      chk("clr_lo", bus.Z_LO, 32'd0);
      dones = 0;
      repeat (28) begin
         @(negedge clk);
         dones += int'(bus.done);
      end
      chk("clr_no_done", dones, 32'd0);
      full_op("u50d5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle restoring divider that produces the Z_HI/Z_LO pair consumed by the datapath bus multiplexer (bus select 18 = Z_HI, 19 = Z_LO).
- Executes the DIV instruction:
  - Z_LO holds the quotient.
  - Z_HI holds the remainder.
- Operands are taken from the Y register and the bus.
- The control unit starts the operation and waits for done before asserting Z_HIout/Z_LOout.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is supported in this design.
- ITERS, WIDTH, number of shift/subtract iterations.

Ports:
- clock  in  1  rising-edge clock
- clear  in  1  synchronous active-high reset
- start  in  1  request; sampled only in IDLE
- signed_op  in  1  1 = two's-complement divide, 0 = unsigned divide
- dividend  in  32  numerator, sampled on the accepting edge
- divisor  in  32  denominator, sampled on the accepting edge
- Z_HI  out  32  remainder register (feeds bus mux input Z_HI)
- Z_LO  out  32  quotient register (feeds bus mux input Z_LO)
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when results update
- div_by_zero  out  1  sticky flag for the last operation

Behaviour:
- Clock and reset: one clock. clear is synchronous, active-high, and has priority over all other inputs.
- Reset values: Z_HI=0, Z_LO=0, busy=0, done=0, div_by_zero=0, state=IDLE.
- States: IDLE, ITER, FIX.
  - IDLE -> ITER on start with divisor != 0.
  - IDLE stays IDLE on start with divisor == 0 (zero-divisor path below).
  - ITER -> FIX after ITERS iterations.
  - FIX -> IDLE unconditionally.
- Accept edge k (IDLE, start=1):
  - Latch the operand magnitudes, the quotient sign and the remainder sign.
  - Magnitude: if signed_op and bit31=1, use two's-complement negation, held as a 32-bit unsigned value; otherwise use the operand unchanged.
  - Clear the 33-bit partial remainder. Clear iteration counter to 0. Clear div_by_zero.
- ITER, once per edge:
  - Shift {rem, quo} left 1.
  - Trial subtract the divisor magnitude from the 33-bit remainder.
  - If non-negative, keep the difference and set the quotient LSB to 1.
  - Increment the counter. After 32 iterations, move to FIX.
- FIX edge (k+33):
  - Z_LO = quotient, negated if signed_op and the operand signs differ.
  - Z_HI = remainder, negated if signed_op and the dividend was negative.
  - done=1 for exactly this cycle.
  - busy=0 from this edge onward.
- Rounding: truncation toward zero. The remainder takes the sign of the dividend.
- busy: 1 from edge k through edge k+32 inclusive, 0 otherwise.
- Latency: results are visible and done=1 in the cycle after edge k+33. Total 33 clocks from acceptance.
- Zero divisor (accepted with divisor==0, either mode):
  - At edge k+1: Z_LO=0xFFFFFFFF, Z_HI=dividend (raw), div_by_zero=1, done=1.
  - busy=1 only for the cycle between k and k+1. No iteration is performed.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives Z_LO=0x80000000, Z_HI=0. This is a natural wrap. No flag is raised.
- start while busy: ignored, no queuing. Operands and results are unaffected.
- start in the same cycle as done: ignored. It is accepted only on a following IDLE cycle.
- clear mid-operation: at the next edge, return to IDLE. Z_HI/Z_LO are zeroed and no done pulse is generated.
- Z_HI/Z_LO hold their values between operations. They are not modified during ITER; internal working registers are separate.
- Operand inputs may change freely after the accept edge.

Test Plan:
1. Signed 100 / 7, start at edge k:
   - busy=1 for 33 cycles.
   - done pulse at k+33.
   - Z_LO=0x0000000E, Z_HI=0x00000002.
2. Signed -100 / 7:
   - Z_LO=0xFFFFFFF2, Z_HI=0xFFFFFFFE.
   - Then signed 100 / -7: Z_LO=0xFFFFFFF2, Z_HI=0x00000002.
3. Unsigned 0xFFFFFFFF / 2:
   - Z_LO=0x7FFFFFFF, Z_HI=0x00000001.
   - Same operands signed (-1 / 2): Z_LO=0, Z_HI=0xFFFFFFFF.
4. Zero divisor and flag clearing:
   - 0x1234 / 0: at k+1, Z_LO=0xFFFFFFFF, Z_HI=0x00001234, div_by_zero=1, done=1.
   - Next 9 / 3: div_by_zero clears at accept; result Z_LO=3, Z_HI=0.
5. Overflow and ignored start:
   - Signed 0x80000000 / 0xFFFFFFFF: Z_LO=0x80000000, Z_HI=0.
   - Pulse start with new operands at k+10: ignored; result and done timing unchanged.
6. clear mid-operation:
   - Start 100 / 7, assert clear at k+12.
   - Next cycle: busy=0, Z_HI=Z_LO=0, no done through k+40.
   - Fresh start of 50 / 5 completes with Z_LO=10, Z_HI=0 after 33 cycles.
